systolic_feeder: RTL and testbench
==================================

// Module: systolic_feeder
// PURPOSE
//  Transmit side of the processing-element edge interface. Buffers an N x N matrix A and an
//  N x N matrix B, where N = MAX_DIM. It then drives the skewed operand wavefronts into the
//  left column and top row of the PE array, together with the start and mode qualifiers the
//  PEs expect. It sits between the host load path and the systolic matrix-multiply array.
// PARAMETERS
//  DATA_WIDTH  8   width of one signed matrix element.
//  BUS_WIDTH   32  width of one load word, which carries one full matrix row.
//  MAX_DIM     (localparam) BUS_WIDTH/DATA_WIDTH = N, the array dimension. The default is 4.
// PORTS
//  clk_i      in   1              clock; all logic on the rising edge.
//  rst_i      in   1              synchronous reset, active-high.
//  wr_en_i    in   1              write one matrix row this cycle.
//  wr_sel_i   in   1              row target: 0 = A, 1 = B.
//  wr_row_i   in   $clog2(N)      row index r.
//  wr_data_i  in   BUS_WIDTH      element k at [k*DATA_WIDTH +: DATA_WIDTH].
//  start_i    in   1              request a run; sampled only in IDLE.
//  mode_i     in   1              accumulate-with-C flag; latched at start.
//  left_o     out  N*DATA_WIDTH   lane i drives PE row i left_i, at [i*DW +: DW].
//  up_o       out  N*DATA_WIDTH   lane j drives PE column j up_i.
//  start_o    out  1              start_bit to the array.
//  mode_o     out  1              mode_bit to the array.
//  busy_o     out  1              high whenever state != IDLE.
//  done_o     out  1              one-cycle pulse at the end of a run.
//  wr_drop_o  out  1              sticky: a write was rejected while busy.
// BEHAVIOUR
//  Reset:
//  - All outputs are 0. State goes to IDLE. Both buffers are cleared to 0.
//  - Reset mid-run aborts immediately. On the next cycle start_o=0 and all lanes are 0.
//  Load:
//  - In IDLE, wr_en_i writes wr_data_i into row wr_row_i of A or B (selected by wr_sel_i).
//  - A write outside IDLE is ignored, leaves both buffers unchanged, and sets wr_drop_o.
//  - wr_drop_o is cleared only by rst_i or an accepted start_i.
//  FSM: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  - IDLE: when start_i=1, latch mode_i into mode_o, clear the step counter, go to FEED.
//  - If wr_en_i and start_i occur together in IDLE, the write commits first and the run uses it.
//  - FEED: 3N-2 cycles, step t = 0..3N-3; t=0 is the first cycle after start is accepted.
//  - DRAIN: 2 cycles; all lanes 0; start_o stays 1 to cover the PE multiply/accumulate pipeline.
//  - DONE: 1 cycle; done_o=1, start_o=0, lanes 0. Next state is IDLE.
//  - start_i is ignored in FEED, DRAIN and DONE.
//  Wavefront (all outputs registered, driven during step t):
//  - left lane i = A[i][t-i] when 0 <= t-i < N, otherwise 0.
//  - up lane j   = B[t-j][j] when 0 <= t-j < N, otherwise 0.
//  - Elements are passed through bit-exact; no arithmetic or sign extension is applied.
//  Qualifiers:
//  - start_o is high for exactly 3N cycles per run (FEED + DRAIN) and low otherwise.
//  - busy_o is high for 3N+1 cycles per run.
//  - mode_o holds its latched value until the next accepted start_i.
//  - Total latency is 3N+1 cycles from start_i acceptance to the done_o pulse; 13 cycles for N=4.
// TESTING (N=4, DATA_WIDTH=8)
//  1. Reset: assert rst_i for 2 cycles -> all outputs 0, busy_o=0, and a run with no loads
//     drives all-zero lanes.
//  2. Skew: load A[i][k]=16i+k and start -> left lane 2 over t=0..9 is
//     0,0,0x20,0x21,0x22,0x23,0,0,0,0; lane 0 carries 0x00..0x03 at t=0..3.
//  3. Column skew: load B[k][j]=16k+j and start -> up lane 3 over t=3..6 is 0x03,0x13,0x23,0x33,
//     and 0 elsewhere.
//  4. Timing: start with mode_i=1 -> mode_o=1; start_o high for 12 cycles; done_o pulses on
//     cycle 13; busy_o drops the cycle after.
//  5. Busy protection: issue wr_en_i during FEED, then start_i during DRAIN -> buffers unchanged,
//     wr_drop_o=1, no second run; wr_drop_o clears on the next accepted start.
//  6. Abort: assert rst_i at FEED step 5 -> next cycle all outputs 0 and state IDLE; a new run
//     after reset feeds zeros.

Source files
------------

// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N systolic array: buffers A and B row-wise, then streams
// skewed operand wavefronts into the left column and top row with start/mode qualifiers.

module feeder_lane #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int SW   = 4,
  parameter int LANE = 0
) (
  input  logic [N-1:0][DW-1:0] vec,
  input  logic [SW-1:0]        step,
  input  logic                 en,
  output logic [DW-1:0]        elem
);
  // lane LANE carries vec[k] at step LANE+k, zero outside that window
  always_comb begin
    elem = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (step == SW'(LANE + k)) elem = vec[k];
      end
    end
  end
endmodule

module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        wr_en_i,
  input  logic                                        wr_sel_i,
  input  logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]     wr_row_i,
  input  logic [BUS_WIDTH-1:0]                        wr_data_i,
  input  logic                                        start_i,
  input  logic                                        mode_i,
  output logic [BUS_WIDTH-1:0]                        left_o,
  output logic [BUS_WIDTH-1:0]                        up_o,
  output logic                                        start_o,
  output logic                                        mode_o,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        wr_drop_o
);
  localparam int N    = BUS_WIDTH / DATA_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int SW   = $clog2(3 * N);
  localparam int LAST = 3 * N - 3;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                      state, nxt_state;
  logic [SW-1:0]               step, nxt_step;
  logic [N-1:0][N-1:0][DW-1:0] a_buf, b_buf, a_view, b_view, b_col;
  logic [N-1:0][DW-1:0]        left_q, up_q, left_d, up_d;
  logic                        mode_q, drop_q;
  logic                        idle, feed_nxt, accept;

  assign idle     = (state == IDLE);
  assign accept   = idle && start_i;
  assign feed_nxt = (nxt_state == FEED);

  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    case (state)
      IDLE: if (start_i) begin
        nxt_state = FEED;
        nxt_step  = '0;
      end
      FEED: if (step == SW'(LAST)) begin
        nxt_state = DRAIN;
        nxt_step  = '0;
      end else begin
        nxt_step = step + SW'(1);
      end
      DRAIN: if (step == SW'(1)) begin
        nxt_state = DONE;
      end else begin
        nxt_step = step + SW'(1);
      end
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Buffers as they will be after this cycle's write, so a write that coincides
  // with start already feeds step 0.
  always_comb begin
    a_view = a_buf;
    b_view = b_buf;
    if (idle && wr_en_i) begin
      if (wr_sel_i) b_view[wr_row_i] = wr_data_i;
      else          a_view[wr_row_i] = wr_data_i;
    end
  end

  always_comb begin
    b_col = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        b_col[j][k] = b_view[k][j];
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    feeder_lane #(.N(N), .DW(DW), .SW(SW), .LANE(g)) u_left (
      .vec(a_view[g]), .step(nxt_step), .en(feed_nxt), .elem(left_d[g]));
    feeder_lane #(.N(N), .DW(DW), .SW(SW), .LANE(g)) u_up (
      .vec(b_col[g]), .step(nxt_step), .en(feed_nxt), .elem(up_d[g]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      step   <= '0;
      a_buf  <= '0;
      b_buf  <= '0;
      left_q <= '0;
      up_q   <= '0;
      mode_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      step   <= nxt_step;
      a_buf  <= a_view;
      b_buf  <= b_view;
      left_q <= left_d;
      up_q   <= up_d;
      if (accept) mode_q <= mode_i;
      if (accept)                drop_q <= 1'b0;
      else if (wr_en_i && !idle) drop_q <= 1'b1;
    end
  end

  assign left_o    = left_q;
  assign up_o      = up_q;
  assign start_o   = (state == FEED) || (state == DRAIN);
  assign mode_o    = mode_q;
  assign busy_o    = !idle;
  assign done_o    = (state == DONE);
  assign wr_drop_o = drop_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-cycle expectations are queued when a run
// is launched and popped as the DUT drives each cycle.

module tb_systolic_feeder;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0, wr_sel_i = 1'b0;
  logic [1:0]  wr_row_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        start_i = 1'b0, mode_i = 1'b0;
  logic [31:0] left_o, up_o;
  logic        start_o, mode_o, busy_o, done_o, wr_drop_o;

  systolic_feeder #(.DATA_WIDTH(8), .BUS_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_row_i(wr_row_i), .wr_data_i(wr_data_i), .start_i(start_i), .mode_i(mode_i),
    .left_o(left_o), .up_o(up_o), .start_o(start_o), .mode_o(mode_o),
    .busy_o(busy_o), .done_o(done_o), .wr_drop_o(wr_drop_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] left;
    logic [31:0] up;
    logic [4:0]  flags; // {start, busy, done, mode, drop}
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ma[4][4];
  logic [7:0] mb[4][4];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {start_o, busy_o, done_o, mode_o, wr_drop_o};
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'h00;
        mb[r][c] = 8'h00;
      end
  endtask

  task automatic model_write(input logic sel, input int row, input logic [31:0] d);
    for (int c = 0; c < 4; c++) begin
      if (sel) mb[row][c] = d[c*8 +: 8];
      else     ma[row][c] = d[c*8 +: 8];
    end
  endtask

  // Entered just after a negedge; leaves just after a negedge.
  task automatic load(input logic sel, input int row, input logic [31:0] d);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_row_i = 2'(row); wr_data_i = d;
    @(negedge clk);
    wr_en_i = 1'b0;
    model_write(sel, row, d);
  endtask

  task automatic run(input logic m, input logic cw, input logic cw_sel, input int cw_row,
                     input logic [31:0] cw_data, input int wr_at, input int st_at,
                     input int abort_at);
    exp_t x;
    int   n, e;
    if (cw) model_write(cw_sel, cw_row, cw_data);
    n = (abort_at >= 0) ? abort_at + 1 : 14;
    for (int s = 0; s < n; s++) begin
      x.left = '0; x.up = '0;
      // element (i,k) of A enters row i at step i+k; B(k,j) enters column j at k+j
      if (s < 10) begin
        for (int i = 0; i < 4; i++)
          for (int k = 0; k < 4; k++) begin
            if (i + k == s) x.left[i*8 +: 8] = ma[i][k];
            if (k + i == s) x.up[i*8 +: 8]   = mb[k][i];
          end
      end
      x.flags[4] = (s < 12);
      x.flags[3] = (s < 13);
      x.flags[2] = (s == 12);
      x.flags[1] = m;
      x.flags[0] = (wr_at >= 0) && (s > wr_at);
      sb.push_back(x);
    end
    if (abort_at >= 0) begin
      x.left = '0; x.up = '0; x.flags = '0;
      sb.push_back(x);
    end
    start_i = 1'b1; mode_i = m;
    if (cw) begin
      wr_en_i = 1'b1; wr_sel_i = cw_sel; wr_row_i = 2'(cw_row); wr_data_i = cw_data;
    end
    @(negedge clk);
    start_i = 1'b0; mode_i = 1'b0; wr_en_i = 1'b0;
    e = 0;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk($sformatf("left[%0d]", e), 64'(left_o), 64'(x.left));
      chk($sformatf("up[%0d]", e), 64'(up_o), 64'(x.up));
      chk($sformatf("flags[%0d]", e), 64'(dut_flags()), 64'(x.flags));
      if (e == wr_at) begin
        wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = 2'd1; wr_data_i = 32'hDEADBEEF;
      end
      if (e == st_at) begin
        start_i = 1'b1; mode_i = ~m;
      end
      if (e == abort_at) begin
        rst_i = 1'b1;
        clear_model();
      end
      @(negedge clk);
      wr_en_i = 1'b0; start_i = 1'b0; mode_i = 1'b0; rst_i = 1'b0;
      e++;
    end
  endtask

  initial begin
    logic [31:0] row;
    clear_model();
    // reset for two cycles, outputs checked while still in reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_left", 64'(left_o), 64'h0);
    chk("rst_up", 64'(up_o), 64'h0);
    chk("rst_flags", 64'(dut_flags()), 64'h0);
    rst_i = 1'b0;

    run(1'b0, 1'b0, 1'b0, 0, 32'h0, -1, -1, -1);          // empty buffers feed zeros

    for (int i = 0; i < 4; i++) begin                      // A[i][k] = 16i+k
      for (int k = 0; k < 4; k++) row[k*8 +: 8] = 8'(16*i + k);
      load(1'b0, i, row);
    end
    run(1'b0, 1'b0, 1'b0, 0, 32'h0, -1, -1, -1);

    for (int k = 0; k < 3; k++) begin                      // B[k][j] = 16k+j, row 3 with start
      for (int j = 0; j < 4; j++) row[j*8 +: 8] = 8'(16*k + j);
      load(1'b1, k, row);
    end
    for (int j = 0; j < 4; j++) row[j*8 +: 8] = 8'(48 + j);
    run(1'b1, 1'b1, 1'b1, 3, row, -1, -1, -1);
    chk("lane3_t6_const", 64'(mb[3][3]), 64'h33);

    run(1'b0, 1'b0, 1'b0, 0, 32'h0, 3, 10, -1);            // busy write + ignored start
    run(1'b1, 1'b0, 1'b0, 0, 32'h0, -1, -1, -1);           // same data, drop cleared

    load(1'b0, 2, 32'hF0E0D0C0);
    run(1'b0, 1'b0, 1'b0, 0, 32'h0, -1, -1, 5);            // abort at step 5
    run(1'b0, 1'b0, 1'b0, 0, 32'h0, -1, -1, -1);           // buffers cleared by reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
